// File: rtl/psram_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | psram_pkg : shared state encoding and opcodes for the PSRAM model     |
// | Revision  : 1.0                                                       |
// +----------------------------------------------------------------------+
package psram_pkg;

  typedef enum logic [2:0] {
    ST_CMD   = 3'd0,
    ST_ADDR  = 3'd1,
    ST_WDATA = 3'd2,
    ST_WAIT  = 3'd3,
    ST_RDATA = 3'd4,
    ST_DONE  = 3'd5,
    ST_BAD   = 3'd6
  } state_t;

  localparam logic [7:0] CMD_QWRITE = 8'h38;
  localparam logic [7:0] CMD_QREAD  = 8'hEB;
  localparam logic [7:0] CMD_QPI_EN = 8'h35;
  localparam logic [7:0] CMD_QPI_EX = 8'hF5;

  localparam int CNT_W = 8;

endpackage
`default_nettype wire

// File: rtl/psram_mem.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | psram_mem : byte array, one sync write port, one async read port      |
// | Revision  : 1.0                                                       |
// +----------------------------------------------------------------------+
module psram_mem #(
  parameter int DEPTH = 4096
) (
  input  logic                     clk_i,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] addr_i,
  input  logic [7:0]               wdata_i,
  output logic [7:0]               rdata_o
);

  logic [7:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[addr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[addr_i];

endmodule
`default_nettype wire

// File: rtl/psram_qspi_dev.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | psram_qspi_dev : QSPI/QPI PSRAM device model (0x38/0xEB/0x35/0xF5)    |
// | Revision       : 1.0                                                  |
// +----------------------------------------------------------------------+
module psram_qspi_dev
  import psram_pkg::*;
#(
  parameter int ADDR_BITS   = 24,
  parameter int MEM_DEPTH   = 4096,
  parameter int READ_WAIT   = 6,
  parameter int QPI_DEFAULT = 0
) (
  input  logic       sck,
  input  logic       reset,
  input  logic       ce_n,
  input  logic [3:0] dio_i,
  output logic [3:0] dio_o,
  output logic       dio_oe,
  output logic       qpi_mode,
  output logic       err,
  output logic [7:0] err_cmd
);

  localparam int AW = $clog2(MEM_DEPTH);
  localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_BITS / 4 - 1);
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(READ_WAIT - 1);

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [7:0]           cmd_q, cmd_d;
  logic [ADDR_BITS-1:0] addr_q, addr_d;
  logic [3:0]           wnib_q, wnib_d;
  logic                 half_q, half_d;
  logic                 qpi_q, qpi_d;
  logic                 err_q, err_d;
  logic [7:0]           err_cmd_q, err_cmd_d;

  logic       w_arst;
  logic       w_cmd_last;
  logic [7:0] w_opcode;
  logic       w_mem_we;
  logic [7:0] w_mem_rdata;

  // Deasserting chip enable acts as a transaction-level async reset.
  assign w_arst     = reset | ce_n;
  assign w_cmd_last = qpi_q ? (cnt_q == CNT_W'(1)) : (cnt_q == CNT_W'(7));
  assign w_opcode   = qpi_q ? {cmd_q[3:0], dio_i} : {cmd_q[6:0], dio_i[0]};

  always_ff @(posedge sck or posedge w_arst) begin
    if (w_arst) begin
      state_q <= ST_CMD;
      cnt_q   <= '0;
      cmd_q   <= '0;
      addr_q  <= '0;
      wnib_q  <= '0;
      half_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cmd_q   <= cmd_d;
      addr_q  <= addr_d;
      wnib_q  <= wnib_d;
      half_q  <= half_d;
    end
  end

  // Mode and error flags survive ce_n; only reset clears them.
  always_ff @(posedge sck or posedge reset) begin
    if (reset) begin
      qpi_q     <= 1'(QPI_DEFAULT);
      err_q     <= 1'b0;
      err_cmd_q <= '0;
    end else if (!ce_n) begin
      qpi_q     <= qpi_d;
      err_q     <= err_d;
      err_cmd_q <= err_cmd_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    cmd_d     = cmd_q;
    addr_d    = addr_q;
    wnib_d    = wnib_q;
    half_d    = half_q;
    qpi_d     = qpi_q;
    err_d     = err_q;
    err_cmd_d = err_cmd_q;
    case (state_q)
      ST_CMD: begin
        cmd_d = w_opcode;
        cnt_d = cnt_q + 1'b1;
        if (w_cmd_last) begin
          cnt_d = '0;
          if (w_opcode == CMD_QWRITE || w_opcode == CMD_QREAD) begin
            state_d = ST_ADDR;
          end else if (w_opcode == CMD_QPI_EN) begin
            qpi_d   = 1'b1;
            state_d = ST_DONE;
          end else if (w_opcode == CMD_QPI_EX && qpi_q) begin
            qpi_d   = 1'b0;
            state_d = ST_DONE;
          end else begin
            err_d   = 1'b1;
            if (!err_q) err_cmd_d = w_opcode;
            state_d = ST_BAD;
          end
        end
      end
      ST_ADDR: begin
        addr_d = ADDR_BITS'({addr_q, dio_i});
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == ADDR_LAST) begin
          cnt_d   = '0;
          half_d  = 1'b0;
          state_d = (cmd_q == CMD_QREAD) ? ST_WAIT : ST_WDATA;
        end
      end
      ST_WDATA: begin
        half_d = ~half_q;
        if (!half_q) wnib_d = dio_i;
        else         addr_d = addr_q + 1'b1;
      end
      ST_WAIT: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == WAIT_LAST) begin
          cnt_d   = '0;
          half_d  = 1'b0;
          state_d = ST_RDATA;
        end
      end
      ST_RDATA: begin
        half_d = ~half_q;
        if (half_q) addr_d = addr_q + 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    dio_oe   = (state_q == ST_RDATA);
    w_mem_we = (state_q == ST_WDATA) && half_q;
    dio_o    = 4'h0;
    if (dio_oe) dio_o = half_q ? w_mem_rdata[3:0] : w_mem_rdata[7:4];
  end

  assign qpi_mode = qpi_q;
  assign err      = err_q;
  assign err_cmd  = err_cmd_q;

  psram_mem #(
    .DEPTH(MEM_DEPTH)
  ) u_mem (
    .clk_i  (sck),
    .we_i   (w_mem_we),
    .addr_i (addr_q[AW-1:0]),
    .wdata_i({wnib_q, dio_i}),
    .rdata_o(w_mem_rdata)
  );

endmodule
`default_nettype wire

// File: tb/tb_psram_qspi_dev.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_psram_qspi_dev : scoreboard bench for the QSPI/QPI PSRAM model     |
// | Revision          : 1.0                                               |
// +----------------------------------------------------------------------+
module tb_psram_qspi_dev;

  localparam int RW = 6;

  logic       sck = 1'b0;
  logic       reset = 1'b1;
  logic       ce_n = 1'b1;
  logic [3:0] dio_i = 4'h0;
  logic [3:0] dio_o;
  logic       dio_oe;
  logic       qpi_mode;
  logic       err;
  logic [7:0] err_cmd;

  int errors = 0;
  int checks = 0;

  logic       m_qpi = 1'b0;
  logic [7:0] m_mem [4096];
  logic [7:0] exp_q [$];
  logic [7:0] got_q [$];

  psram_qspi_dev #(
    .ADDR_BITS(24), .MEM_DEPTH(4096), .READ_WAIT(RW), .QPI_DEFAULT(0)
  ) dut (
    .sck(sck), .reset(reset), .ce_n(ce_n), .dio_i(dio_i), .dio_o(dio_o),
    .dio_oe(dio_oe), .qpi_mode(qpi_mode), .err(err), .err_cmd(err_cmd)
  );

  task automatic sck_edge(input logic [3:0] nib);
    dio_i = nib;
    #5 sck = 1'b1;
    #5 sck = 1'b0;
  endtask

  task automatic begin_txn;
    ce_n = 1'b0;
    #5;
  endtask

  task automatic end_txn;
    #3 ce_n = 1'b1;
    #5;
  endtask

  task automatic send_cmd(input logic [7:0] op);
    if (m_qpi) begin
      sck_edge(op[7:4]);
      sck_edge(op[3:0]);
    end else begin
      for (int i = 7; i >= 0; i--) sck_edge({3'b000, op[i]});
    end
  endtask

  task automatic send_addr(input logic [23:0] a);
    for (int i = 5; i >= 0; i--) sck_edge(a[i*4 +: 4]);
  endtask

  task automatic write_txn(input logic [23:0] a, input logic [15:0] data, input int n);
    logic [7:0]  b;
    logic [11:0] ia;
    begin_txn();
    send_cmd(8'h38);
    send_addr(a);
    for (int k = 0; k < n; k++) begin
      b = (k == 0) ? data[15:8] : data[7:0];
      sck_edge(b[7:4]);
      sck_edge(b[3:0]);
      ia = a[11:0] + 12'(k);
      m_mem[ia] = b;
    end
    end_txn();
  endtask

  task automatic read_start(input logic [23:0] a, output logic [15:0] oe_tr);
    oe_tr = 16'h0000;
    begin_txn();
    send_cmd(8'hEB);
    send_addr(a);
    for (int i = 0; i < RW; i++) begin
      sck_edge(4'h0);
      oe_tr[i] = dio_oe;
    end
  endtask

  task automatic read_bytes(input logic [23:0] a, input int n);
    logic [3:0]  hi;
    logic [3:0]  lo;
    logic [11:0] ia;
    for (int k = 0; k < n; k++) begin
      ia = a[11:0] + 12'(k);
      exp_q.push_back(m_mem[ia]);
      hi = dio_o;
      sck_edge(4'h0);
      lo = dio_o;
      sck_edge(4'h0);
      got_q.push_back({hi, lo});
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    #10;
    checks++; if (dio_oe !== 1'b0)   begin errors++; $display("FAIL reset_oe got=%b exp=0", dio_oe); end
    checks++; if (dio_o !== 4'h0)    begin errors++; $display("FAIL reset_dio got=%h exp=0", dio_o); end
    checks++; if (qpi_mode !== 1'b0) begin errors++; $display("FAIL reset_qpi got=%b exp=0", qpi_mode); end
    checks++; if (err !== 1'b0)      begin errors++; $display("FAIL reset_err got=%b exp=0", err); end
    checks++; if (err_cmd !== 8'h00) begin errors++; $display("FAIL reset_err_cmd got=%h exp=00", err_cmd); end
    reset = 1'b0;
    #5;
  endtask

  task automatic test_spi_write_read;
    logic [15:0] oe_tr;
    logic [7:0]  e, g;
    write_txn(24'h000010, 16'hA53C, 2);
    read_start(24'h000010, oe_tr);
    checks++; if (oe_tr !== 16'h0020) begin errors++; $display("FAIL wait_oe_trace got=%h exp=0020", oe_tr); end
    read_bytes(24'h000010, 2);
    end_txn();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = (got_q.size() > 0) ? got_q.pop_front() : 8'hxx;
      checks++; if (g !== e) begin errors++; $display("FAIL spi_read got=%h exp=%h", g, e); end
    end
  endtask

  task automatic test_wrap;
    logic [15:0] oe_tr;
    logic [7:0]  e, g;
    write_txn(24'h000FFF, 16'h1122, 2);
    write_txn(24'h001030, 16'h5A00, 1);
    read_start(24'h000000, oe_tr);
    read_bytes(24'h000000, 1);
    end_txn();
    read_start(24'h000FFF, oe_tr);
    read_bytes(24'h000FFF, 2);
    end_txn();
    read_start(24'h000030, oe_tr);
    read_bytes(24'h000030, 1);
    end_txn();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = (got_q.size() > 0) ? got_q.pop_front() : 8'hxx;
      checks++; if (g !== e) begin errors++; $display("FAIL wrap_alias_read got=%h exp=%h", g, e); end
    end
  endtask

  task automatic test_qpi;
    logic [15:0] oe_tr;
    logic [7:0]  e, g;
    begin_txn(); send_cmd(8'h35); end_txn();
    m_qpi = 1'b1;
    checks++; if (qpi_mode !== 1'b1) begin errors++; $display("FAIL qpi_enter got=%b exp=1", qpi_mode); end
    read_start(24'h000010, oe_tr);
    checks++; if (oe_tr !== 16'h0020) begin errors++; $display("FAIL qpi_wait_oe got=%h exp=0020", oe_tr); end
    read_bytes(24'h000010, 2);
    end_txn();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = (got_q.size() > 0) ? got_q.pop_front() : 8'hxx;
      checks++; if (g !== e) begin errors++; $display("FAIL qpi_read got=%h exp=%h", g, e); end
    end
    begin_txn(); send_cmd(8'hF5); end_txn();
    m_qpi = 1'b0;
    checks++; if (qpi_mode !== 1'b0) begin errors++; $display("FAIL qpi_exit got=%b exp=0", qpi_mode); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL qpi_exit_err got=%b exp=0", err); end
    begin_txn(); send_cmd(8'hF5); end_txn();
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL spi_f5_err got=%b exp=1", err); end
    checks++; if (err_cmd !== 8'hF5) begin errors++; $display("FAIL spi_f5_err_cmd got=%h exp=f5", err_cmd); end
    checks++; if (qpi_mode !== 1'b0) begin errors++; $display("FAIL spi_f5_qpi got=%b exp=0", qpi_mode); end
  endtask

  task automatic test_bad_opcode;
    logic [15:0] oe_tr;
    logic [7:0]  e, g;
    logic        any_oe;
    reset = 1'b1; #5; reset = 1'b0; #5;
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL err_cleared got=%b exp=0", err); end
    begin_txn();
    send_cmd(8'h9F);
    any_oe = 1'b0;
    for (int i = 0; i < 20; i++) begin
      sck_edge(4'hF);
      any_oe = any_oe | dio_oe;
    end
    end_txn();
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL bad_err got=%b exp=1", err); end
    checks++; if (err_cmd !== 8'h9F) begin errors++; $display("FAIL bad_err_cmd got=%h exp=9f", err_cmd); end
    checks++; if (any_oe !== 1'b0) begin errors++; $display("FAIL bad_oe got=%b exp=0", any_oe); end
    begin_txn(); send_cmd(8'h9E); end_txn();
    checks++; if (err_cmd !== 8'h9F) begin errors++; $display("FAIL err_cmd_sticky got=%h exp=9f", err_cmd); end
    write_txn(24'h000100, 16'hC300, 1);
    read_start(24'h000100, oe_tr);
    read_bytes(24'h000100, 1);
    end_txn();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = (got_q.size() > 0) ? got_q.pop_front() : 8'hxx;
      checks++; if (g !== e) begin errors++; $display("FAIL after_bad_read got=%h exp=%h", g, e); end
    end
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_sticky got=%b exp=1", err); end
  endtask

  task automatic test_abort;
    logic [15:0] oe_tr;
    logic [7:0]  e, g;
    write_txn(24'h000020, 16'h7700, 1);
    begin_txn();
    send_cmd(8'h38);
    send_addr(24'h000020);
    sck_edge(4'hE);
    end_txn();
    read_start(24'h000020, oe_tr);
    read_bytes(24'h000020, 1);
    checks++; if (dio_oe !== 1'b1) begin errors++; $display("FAIL abort_pre_oe got=%b exp=1", dio_oe); end
    #3 ce_n = 1'b1;
    #1;
    checks++; if (dio_oe !== 1'b0) begin errors++; $display("FAIL abort_oe got=%b exp=0", dio_oe); end
    #4;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = (got_q.size() > 0) ? got_q.pop_front() : 8'hxx;
      checks++; if (g !== e) begin errors++; $display("FAIL partial_write_read got=%h exp=%h", g, e); end
    end
  endtask

  task automatic test_reset_mid_read;
    logic [15:0] oe_tr;
    logic [7:0]  e, g;
    begin_txn(); send_cmd(8'h35); end_txn();
    m_qpi = 1'b1;
    read_start(24'h000010, oe_tr);
    read_bytes(24'h000010, 1);
    checks++; if (dio_oe !== 1'b1) begin errors++; $display("FAIL mid_pre_oe got=%b exp=1", dio_oe); end
    #2 reset = 1'b1;
    #1;
    checks++; if (dio_oe !== 1'b0)   begin errors++; $display("FAIL mid_reset_oe got=%b exp=0", dio_oe); end
    checks++; if (qpi_mode !== 1'b0) begin errors++; $display("FAIL mid_reset_qpi got=%b exp=0", qpi_mode); end
    #2 reset = 1'b0;
    m_qpi = 1'b0;
    end_txn();
    read_start(24'h000010, oe_tr);
    read_bytes(24'h000010, 2);
    end_txn();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = (got_q.size() > 0) ? got_q.pop_front() : 8'hxx;
      checks++; if (g !== e) begin errors++; $display("FAIL reset_readback got=%h exp=%h", g, e); end
    end
  endtask

  initial begin
    test_reset();
    test_spi_write_read();
    test_wrap();
    test_qpi();
    test_bad_opcode();
    test_abort();
    test_reset_mid_read();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
